// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one 8/N/1 UART transmitter between
// NUM_REQ byte-stream requesters, with optional channel tag byte and stall timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TAG_EN      = 1,
    parameter logic [7:0]  TAG_BASE    = 8'hF0,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [8*NUM_REQ-1:0]       i_req_data,
    input  logic [NUM_REQ-1:0]         i_req_last,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_tx_valid,
    output logic [7:0]                 o_tx_data,
    input  logic                       i_tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] o_grant,
    output logic                       o_busy,
    output logic                       o_abort
);

    localparam int unsigned GW       = $clog2(NUM_REQ);
    localparam int unsigned CW       = (STALL_LIMIT == 0) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam bit          STALL_EN = (STALL_LIMIT != 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_FIRE = (STALL_LIMIT == 0) ? '0 : CW'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAG,
        S_DATA
    } state_e;

    state_e          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   last_grant_q;
    logic [CW-1:0]   stall_cnt_q;
    logic            abort_q;

    logic [GW-1:0]   grant_d;
    logic [GW-1:0]   arb_cand;
    logic            arb_found;
    logic            gnt_valid;
    logic            gnt_last;
    logic            tx_hs;

    assign gnt_valid = i_req_valid[grant_q];
    assign gnt_last  = i_req_last[grant_q];
    assign tx_hs     = o_tx_valid && i_tx_ready;

    // First valid requester scanning upward from last_grant+1, with wrap.
    always_comb begin
        arb_found = 1'b0;
        grant_d   = '0;
        arb_cand  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            arb_cand = GW'((32'(last_grant_q) + i) % NUM_REQ);
            if (!arb_found && i_req_valid[arb_cand]) begin
                arb_found = 1'b1;
                grant_d   = arb_cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            stall_cnt_q  <= '0;
            abort_q      <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arb_found) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        stall_cnt_q  <= '0;
                        state_q      <= (TAG_EN != 0) ? S_TAG : S_DATA;
                    end
                end
                S_TAG: begin
                    if (i_tx_ready) begin
                        stall_cnt_q <= '0;
                        state_q     <= S_DATA;
                    end
                end
                S_DATA: begin
                    // A last-byte handshake wins over a coincident stall expiry.
                    if (tx_hs && gnt_last) begin
                        state_q <= S_IDLE;
                    end else if (STALL_EN && !gnt_valid && (stall_cnt_q == CNT_FIRE)) begin
                        state_q <= S_IDLE;
                        abort_q <= 1'b1;
                    end
                    if (gnt_valid || !STALL_EN) begin
                        stall_cnt_q <= '0;
                    end else if (stall_cnt_q != CNT_MAX) begin
                        stall_cnt_q <= stall_cnt_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Transmit path is combinational; the requester holds its byte until accepted.
    always_comb begin
        o_tx_valid  = 1'b0;
        o_tx_data   = '0;
        o_req_ready = '0;
        case (state_q)
            S_TAG: begin
                o_tx_valid = 1'b1;
                o_tx_data  = TAG_BASE | 8'(grant_q);
            end
            S_DATA: begin
                o_tx_valid           = gnt_valid;
                o_tx_data            = i_req_data[32'(grant_q)*8 +: 8];
                o_req_ready[grant_q] = i_tx_ready;
            end
            default: ;
        endcase
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued expected byte stream from a
// round-robin packet model, popped by a monitor on every transmitter handshake.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;

    typedef logic [7:0] byteq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           tx_valid, tx_ready, busy, abort;
    logic [7:0]     tx_data;
    logic [1:0]     grant;

    logic [N-1:0]   b_valid, b_last, b_ready;
    logic [8*N-1:0] b_data;
    logic           b_tx_valid, b_tx_ready, b_busy, b_abort;
    logic [7:0]     b_tx_data;
    logic [1:0]     b_grant;

    uart_tx_arbiter #(.NUM_REQ(N), .TAG_EN(1), .TAG_BASE(8'hF0), .STALL_LIMIT(8)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
        .o_req_ready(req_ready), .o_tx_valid(tx_valid), .o_tx_data(tx_data),
        .i_tx_ready(tx_ready), .o_grant(grant), .o_busy(busy), .o_abort(abort)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .TAG_EN(0), .TAG_BASE(8'hF0), .STALL_LIMIT(0)) u_dut_notag (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(b_valid), .i_req_data(b_data), .i_req_last(b_last),
        .o_req_ready(b_ready), .o_tx_valid(b_tx_valid), .o_tx_data(b_tx_data),
        .i_tx_ready(b_tx_ready), .o_grant(b_grant), .o_busy(b_busy), .o_abort(b_abort)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    byteq_t     pkt [N];
    bit         no_last [N];
    bit         acc [N];
    int         gap [N];
    int         hs_cnt [N];
    bit         rand_gaps;
    int         tx_mode;
    int         rr_last;
    int         abort_cnt, abort_cyc, drop_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every transmitter handshake must match the head of the expected stream.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %02h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(e));
                end
            end
            if (req_ready != '0) check("ready_onehot", 32'($countones(req_ready)), 32'd1);
            if (abort) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
        end
    end

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k]        = (pkt[k].size() != 0) && (gap[k] == 0);
            req_data[8*k +: 8]  = (pkt[k].size() != 0) ? pkt[k][0] : 8'h00;
            req_last[k]         = (pkt[k].size() == 1) && !no_last[k];
        end
        case (tx_mode)
            0:       tx_ready = ($urandom_range(0, 3) != 0);
            1:       tx_ready = 1'b1;
            default: tx_ready = 1'b0;
        endcase
    endtask

    // One clock: sample accepts before the edge, update requesters just after it.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < N; k++) acc[k] = req_ready[k] && req_valid[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                void'(pkt[k].pop_front());
                hs_cnt[k]++;
                if (pkt[k].size() != 0 && rand_gaps) gap[k] = $urandom_range(0, 3);
                if (pkt[k].size() == 0 && no_last[k]) drop_cyc = cyc;
            end else if (gap[k] > 0) begin
                gap[k]--;
            end
        end
        drive();
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++) if (pkt[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            pkt[k].delete();
            gap[k]     = 0;
            no_last[k] = 1'b0;
            hs_cnt[k]  = 0;
        end
        exp_q.delete();
        abort_cnt = 0;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        rr_last = N - 1;
    endtask

    // Reference: requesters in mask are served in cyclic order after the previous grant.
    task automatic start_round(input logic [N-1:0] mask);
        int k;
        int last_k;
        last_k = rr_last;
        for (int i = 1; i <= N; i++) begin
            k = (rr_last + i) % N;
            if (mask[k]) begin
                exp_q.push_back(8'hF0 | 8'(k));
                foreach (pkt[k][j]) exp_q.push_back(pkt[k][j]);
                last_k = k;
            end
        end
        rr_last = last_k;
        drive();
    endtask

    task automatic rand_pkt(input int k, input int len);
        for (int j = 0; j < len; j++) pkt[k].push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pending() || busy) && n < 3000) begin
            step();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [N-1:0] mask;
        int           n;
        rst        = 1'b1;
        rand_gaps  = 1'b0;
        tx_mode    = 1;
        b_valid    = '0;
        b_last     = '0;
        b_data     = '0;
        b_tx_ready = 1'b0;
        do_reset();

        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_abort", 32'(abort), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_notag_busy", 32'(b_busy), 0);
        @(posedge clk);
        #1;

        // Tag disabled: byte offered the cycle after valid is seen in IDLE.
        b_valid            = 4'b1000;
        b_last             = 4'b1000;
        b_data[31:24]      = 8'h55;
        b_tx_ready         = 1'b1;
        @(negedge clk);
        check("notag_idle_valid", 32'(b_tx_valid), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("notag_valid", 32'(b_tx_valid), 1);
        check("notag_data", 32'(b_tx_data), 32'h55);
        check("notag_grant", 32'(b_grant), 3);
        check("notag_ready", 32'(b_ready), 32'b1000);
        @(posedge clk);
        #1;
        b_valid = '0;
        b_last  = '0;
        @(negedge clk);
        check("notag_after_valid", 32'(b_tx_valid), 0);
        check("notag_after_busy", 32'(b_busy), 0);
        @(posedge clk);
        #1;

        // Single packet from requester 2.
        pkt[2].push_back(8'h41);
        pkt[2].push_back(8'h42);
        pkt[2].push_back(8'h43);
        start_round(4'b0100);
        wait_done("single");
        check("single_accepts", 32'(hs_cnt[2]), 3);

        // Two simultaneous requesters, two rounds.
        do_reset();
        rand_pkt(0, 2);
        rand_pkt(1, 2);
        start_round(4'b0011);
        wait_done("simul1");
        tx_mode = 0;
        rand_pkt(0, 2);
        rand_pkt(1, 2);
        start_round(4'b0011);
        wait_done("simul2");

        // Stall timeout: requester 1 goes silent after one byte, requester 2 waits.
        do_reset();
        tx_mode = 1;
        pkt[1].push_back(8'h11);
        no_last[1] = 1'b1;
        pkt[2].push_back(8'h21);
        pkt[2].push_back(8'h22);
        start_round(4'b0110);
        wait_done("stall");
        check("stall_abort_count", 32'(abort_cnt), 1);
        check("stall_abort_delay", 32'(abort_cyc - drop_cyc), 8);
        no_last[1] = 1'b0;

        // Reset in the middle of a packet.
        do_reset();
        rand_pkt(3, 4);
        start_round(4'b1000);
        n = 0;
        while (exp_q.size() > 3 && n < 100) begin
            step();
            n++;
        end
        check("midrst_progress", 32'(exp_q.size()), 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_all();
        rr_last = N - 1;
        @(negedge clk);
        check("midrst_tx_valid", 32'(tx_valid), 0);
        check("midrst_req_ready", 32'(req_ready), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_abort", 32'(abort), 0);
        check("midrst_grant", 32'(grant), 0);
        @(posedge clk);
        #1;
        repeat (12) step();
        check("midrst_no_abort", 32'(abort_cnt), 0);
        rand_pkt(0, 2);
        rand_pkt(3, 2);
        start_round(4'b1001);
        wait_done("midrst_after");

        // Backpressure: hold tx_ready low for 20 cycles in DATA.
        do_reset();
        pkt[0].push_back(8'hA5);
        pkt[0].push_back(8'h5A);
        start_round(4'b0001);
        n = 0;
        while (exp_q.size() > 2 && n < 50) begin
            step();
            n++;
        end
        tx_mode = 2;
        drive();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_data", 32'(tx_data), 32'hA5);
            check("bp_valid", 32'(tx_valid), 1);
            check("bp_ready", 32'(req_ready), 0);
            @(posedge clk);
            #1;
        end
        check("bp_no_accept", 32'(hs_cnt[0]), 0);
        check("bp_queue", 32'(exp_q.size()), 2);
        tx_mode = 1;
        drive();
        wait_done("bp");

        // Randomized rounds with backpressure and short mid-packet gaps.
        do_reset();
        rand_gaps = 1'b1;
        tx_mode   = 0;
        for (int r = 0; r < 40; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) if (mask[k]) rand_pkt(k, $urandom_range(1, 5));
            start_round(mask);
            wait_done("rand");
            repeat ($urandom_range(0, 2)) step();
        end
        check("rand_no_abort", 32'(abort_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares one 8/N/1 UART transmitter between `NUM_REQ` byte-stream requesters.
- Arbitration is round-robin at packet granularity: once granted, a requester keeps the transmitter until it presents a byte flagged last.
- Each packet is optionally preceded by a channel tag byte, so the host can demultiplex the streams.
- A stall timeout releases a requester that goes silent mid-packet. The block sits between the debug/console sources and the `uart_tx` instance.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `TAG_EN`, 1: 1 = send a tag byte before each packet.
- `TAG_BASE`, 8'hF0: tag byte value is `TAG_BASE | grant_index`. The low 4 bits of `TAG_BASE` must be 0.
- `STALL_LIMIT`, 1024: number of idle cycles mid-packet before the grant is revoked; 0 disables the timeout.

Ports:
- `i_clk`, input, 1: sole clock.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_req_valid`, input, NUM_REQ: per-requester byte valid.
- `i_req_data`, input, 8*NUM_REQ: requester k's byte is `[8k+7:8k]`.
- `i_req_last`, input, NUM_REQ: the presented byte ends the packet.
- `o_req_ready`, output, NUM_REQ: per-requester accept; one-hot or zero.
- `o_tx_valid`, output, 1: byte offered to the transmitter.
- `o_tx_data`, output, 8: byte to transmit.
- `i_tx_ready`, input, 1: transmitter idle/ready; connects to the `uart_tx` ready output.
- `o_grant`, output, $clog2(NUM_REQ): current or most recent grant index.
- `o_busy`, output, 1: high when the state is not IDLE.
- `o_abort`, output, 1: one-cycle pulse when the stall timeout fires.

## Operation

- A transmitter handshake occurs in any cycle with `o_tx_valid && i_tx_ready`.
- A requester handshake occurs in any cycle with `o_req_ready[k] && i_req_valid[k]`.

State machine with three states: IDLE, TAG and DATA.
- **IDLE**
  - `o_tx_valid = 0`, `o_req_ready = 0`.
  - If any `i_req_valid` bit is set, select the first set bit scanning upward from `(last_grant+1) mod NUM_REQ`, with wrap.
  - Register the selection into `grant` and `last_grant`.
  - Go to TAG if `TAG_EN`, else to DATA.
- **TAG**
  - `o_tx_valid = 1`, `o_tx_data = TAG_BASE | grant`.
  - On a transmitter handshake, go to DATA.
  - The tag is sent even if the granted requester drops valid.
- **DATA**
  - `o_tx_valid = i_req_valid[grant]`.
  - `o_tx_data` = the byte of requester `grant`.
  - `o_req_ready[grant] = i_tx_ready`; all other ready bits are 0.
  - On a handshake with `i_req_last[grant]` set, go to IDLE. Otherwise stay in DATA.
- **Stall counter**
  - Applies only in DATA with `STALL_LIMIT != 0`.
  - Cleared on entry to DATA and in every cycle with `i_req_valid[grant] = 1`.
  - Incremented otherwise, saturating.
  - When the count equals `STALL_LIMIT - 1` and valid is still low, go to IDLE and pulse `o_abort`. The partial packet is not terminated on the wire.
  - Counter width is $clog2(STALL_LIMIT+1).
- **Data path:** `o_tx_data` and `o_tx_valid` are combinational from the state, `grant` and the requester inputs. There is no byte buffering inside the block, so the requester holds its data until the handshake.
- **Reset values:**
  - state = IDLE, `grant = 0`, `last_grant = NUM_REQ-1` (requester 0 wins first).
  - Stall counter = 0.
  - All outputs 0: `o_tx_valid`, `o_req_ready`, `o_busy`, `o_abort`, `o_grant`.

## Timing

- **Arbitration latency:** a request first seen in IDLE on cycle t gives state TAG or DATA at t+1. With `TAG_EN = 0`, the first data byte is offered at t+1.
- **Packet turnaround:** after the last-byte handshake at cycle t, the block is in IDLE at t+1 and a new grant is made at t+2. Consecutive packets are therefore separated by at least one IDLE cycle.
- **Reset priority:**
  - `i_rst` overrides all transitions.
  - Reset asserted mid-packet returns to IDLE on the next edge with `o_abort = 0`.
  - The transmitter finishes any byte already accepted; the block does not track this.
- **Arbitration boundary:**
  - Requests arriving while a grant is held are ignored until IDLE.
  - A requester that drops valid before its own grant is simply skipped.
- **Stall vs. last byte:** a last-byte handshake in the same cycle the stall limit would fire counts as a normal end of packet. `o_abort` stays 0.
- **Backpressure:** while `i_tx_ready = 0`, the offered byte and grant are held. Requester data must be stable while its valid is high and ready is low.

## Test plan

- **Single packet:** `NUM_REQ=4`, `TAG_EN=1`, requester 2 sends 0x41, 0x42, 0x43 (last on 0x43), uart_tx model attached. Required serial output: 0xF2, 0x41, 0x42, 0x43. `o_req_ready[2]` pulses exactly 3 times; the block returns to IDLE with `o_busy = 0`.
- **Simultaneous requesters:** requesters 0 and 1 both assert valid with a 2-byte packet each, starting from reset. Required order: F0, p0b0, p0b1, F1, p1b0, p1b1. On a second round with both active, requester 0 follows requester 1 (round-robin wrap).
- **Tag disabled:** `TAG_EN=0`, requester 3 sends a 1-byte packet 0x55. Only 0x55 is transmitted, offered 1 cycle after valid is first sampled in IDLE.
- **Stall timeout:** `STALL_LIMIT=8`, requester 1 sends one non-last byte, then drops valid. `o_abort` pulses once, 8 cycles after valid drops. The next pending requester 2 is granted on the following arbitration.
- **Reset mid-packet:** assert `i_rst` for 1 cycle during DATA. All outputs are 0 the next cycle and `o_abort` never pulses. After release, requester 0 has highest priority.
- **Backpressure hold:** hold `i_tx_ready` low for 20 cycles in DATA. `o_tx_data` stays stable, `o_req_ready` stays 0 and no handshake is counted.
